// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: FSM state encoding and coin selector codes.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam logic COIN_SEL_A = 1'b0;
  localparam logic COIN_SEL_B = 1'b1;

endpackage

// File: rtl/vend_credit_acc.sv
// Credit register with add-coin, subtract-price and decrement-by-one controls.
// Comparisons are taken on the next credit value so the FSM can branch in the same cycle.
module vend_credit_acc #(
  parameter int unsigned PRICE    = 3,
  parameter int unsigned CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                add_en,
  input  logic [CREDIT_W-1:0] add_val,
  input  logic                sub_price,
  input  logic                dec,
  output logic [CREDIT_W-1:0] credit,
  output logic                nxt_ge_price,
  output logic                nxt_zero
);

  localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE_W   = CREDIT_W'(1);

  logic [CREDIT_W-1:0] nxt;

  always_comb begin
    nxt = credit;
    if (add_en)         nxt = credit + add_val;
    else if (sub_price) nxt = credit - PRICE_W;
    else if (dec)       nxt = credit - ONE_W;
  end

  assign nxt_ge_price = (nxt >= PRICE_W);
  assign nxt_zero     = (nxt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) credit <= '0;
    else          credit <= nxt;
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending-machine controller: collects coin credit, strobes dispense at PRICE,
// then returns excess or cancelled credit one unit per ready/valid handshake.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE    = 3,
  parameter int unsigned COIN_A   = 1,
  parameter int unsigned COIN_B   = 2,
  parameter int unsigned CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                coin_valid,
  input  logic                coin_sel,
  input  logic                cancel,
  input  logic                change_ready,
  output logic                dispense,
  output logic                change_valid,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int unsigned MAX_COIN = (COIN_A > COIN_B) ? COIN_A : COIN_B;

  if ((2**CREDIT_W) - 1 < PRICE - 1 + MAX_COIN) begin : g_width_check
    $error("vend_ctrl: CREDIT_W too small for PRICE and coin values");
  end

  localparam logic [CREDIT_W-1:0] COIN_A_W = CREDIT_W'(COIN_A);
  localparam logic [CREDIT_W-1:0] COIN_B_W = CREDIT_W'(COIN_B);

  state_t              state, state_nxt;
  logic                add_en, sub_price, dec;
  logic                nxt_ge_price, nxt_zero;
  logic                reject_nxt;
  logic [CREDIT_W-1:0] coin_val;

  // Accumulator controls depend only on state and inputs, never on the comparisons,
  // keeping the accumulator-to-FSM path free of combinational loops.
  assign coin_val  = (coin_sel == COIN_SEL_B) ? COIN_B_W : COIN_A_W;
  assign add_en    = coin_valid && ((state == IDLE) || ((state == COLLECT) && !cancel));
  assign sub_price = (state == VEND);
  assign dec       = (state == CHANGE) && change_ready;

  vend_credit_acc #(
    .PRICE    (PRICE),
    .CREDIT_W (CREDIT_W)
  ) u_acc (
    .clk          (clk),
    .reset_n      (reset_n),
    .add_en       (add_en),
    .add_val      (coin_val),
    .sub_price    (sub_price),
    .dec          (dec),
    .credit       (credit),
    .nxt_ge_price (nxt_ge_price),
    .nxt_zero     (nxt_zero)
  );

  always_comb begin
    state_nxt  = state;
    reject_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (coin_valid) state_nxt = nxt_ge_price ? VEND : COLLECT;
      end
      COLLECT: begin
        if (cancel) begin
          state_nxt  = CHANGE;
          reject_nxt = coin_valid;
        end else if (coin_valid && nxt_ge_price) begin
          state_nxt = VEND;
        end
      end
      VEND: begin
        reject_nxt = coin_valid;
        state_nxt  = nxt_zero ? IDLE : CHANGE;
      end
      CHANGE: begin
        reject_nxt = coin_valid;
        if (change_ready && nxt_zero) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_nxt;
      coin_reject <= reject_nxt;
    end
  end

  assign dispense     = (state == VEND);
  assign change_valid = (state == CHANGE);
  assign busy         = (state == VEND) || (state == CHANGE);

endmodule
